// File: rtl/edit_field_ctrl_if.sv
// Button inputs and field-control outputs shared between the button front end
// (master) and the edit field controller (slave).
interface edit_field_ctrl_if #(
    parameter int NUM_FIELDS = 4
);
    localparam int SW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    logic                  btn_edit;
    logic                  btn_next;
    logic                  btn_up;
    logic                  btn_down;
    logic                  editing;
    logic [SW-1:0]         field_sel;
    logic [NUM_FIELDS-1:0] field_en;
    logic [1:0]            sb;
    logic                  timeout_pulse;

    modport master (
        output btn_edit, btn_next, btn_up, btn_down,
        input  editing, field_sel, field_en, sb, timeout_pulse
    );

    modport slave (
        input  btn_edit, btn_next, btn_up, btn_down,
        output editing, field_sel, field_en, sb, timeout_pulse
    );
endinterface

// File: rtl/edit_field_ctrl.sv
// Edit-mode sequencer: selects a field, routes single-cycle up/down step pulses
// with hold-to-repeat, and leaves edit mode on a second edit press or inactivity.
module edit_field_ctrl #(
    parameter int NUM_FIELDS  = 4,
    parameter int HOLD_CYC    = 25000000,
    parameter int REPEAT_CYC  = 5000000,
    parameter int TIMEOUT_CYC = 500000000
) (
    input  logic               clk,
    input  logic               rst,
    edit_field_ctrl_if.slave   bus
);
    localparam int SW   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int HMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int HW   = $clog2(HMAX);
    localparam int TW   = $clog2(TIMEOUT_CYC);

    localparam logic [SW-1:0] SEL_LAST  = SW'(NUM_FIELDS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYC - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    localparam int B_ED = 3;
    localparam int B_NX = 2;
    localparam int B_UP = 1;
    localparam int B_DN = 0;

    typedef enum logic {S_IDLE, S_EDIT} state_t;

    state_t                state_q, state_d;
    logic [3:0]            btn_q, btn_d, btn2_q, btn2_d;
    logic                  vld_q, vld_d, armed_q, armed_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [1:0]            step_q, step_d;
    logic                  to_q, to_d;
    logic                  act_q, act_d, dir_up_q, dir_up_d, phase_q, phase_d;
    logic [HW-1:0]         hcnt_q, hcnt_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  editing_q, editing_d;
    logic [SW-1:0]         field_sel_q, field_sel_d;
    logic [NUM_FIELDS-1:0] field_en_q, field_en_d, en_dec;
    logic [1:0]            sb_q, sb_d;
    logic                  timeout_pulse_q, timeout_pulse_d;
    logic [3:0]            rise;

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_en_dec
        assign en_dec[gi] = (state_q == S_EDIT) && (sel_q == SW'(gi));
    end

    // The history register only becomes trustworthy two samples after reset,
    // so a button already held when reset releases never looks like a press.
    always_comb begin
        btn_d   = {bus.btn_edit, bus.btn_next, bus.btn_up, bus.btn_down};
        btn2_d  = btn_q;
        vld_d   = 1'b1;
        armed_d = vld_q;
        rise    = armed_q ? (btn_q & ~btn2_q) : 4'b0000;
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        step_d   = 2'b00;
        to_d     = 1'b0;
        act_d    = act_q;
        dir_up_d = dir_up_q;
        phase_d  = phase_q;
        hcnt_d   = hcnt_q;
        tcnt_d   = tcnt_q;
        case (state_q)
            S_IDLE: begin
                act_d = 1'b0;
                if (rise[B_ED]) begin
                    state_d = S_EDIT;
                    sel_d   = '0;
                    tcnt_d  = '0;
                end
            end
            default: begin
                if (rise[B_ED]) begin
                    state_d = S_IDLE;
                    act_d   = 1'b0;
                end else begin
                    if (rise[B_NX]) begin
                        sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                        act_d = 1'b0;
                    end else if (btn_q[B_UP] && btn_q[B_DN]) begin
                        act_d = 1'b0;
                    end else if (rise[B_UP] || rise[B_DN]) begin
                        step_d   = rise[B_UP] ? 2'b10 : 2'b01;
                        act_d    = 1'b1;
                        dir_up_d = rise[B_UP];
                        phase_d  = 1'b0;
                        hcnt_d   = '0;
                    end else if (act_q && (dir_up_q ? btn_q[B_UP] : btn_q[B_DN])) begin
                        // First interval is the hold delay, later ones the repeat period.
                        if ((!phase_q && hcnt_q == HOLD_LAST) || (phase_q && hcnt_q == REP_LAST)) begin
                            step_d  = dir_up_q ? 2'b10 : 2'b01;
                            hcnt_d  = '0;
                            phase_d = 1'b1;
                        end else begin
                            hcnt_d = hcnt_q + 1'b1;
                        end
                    end else begin
                        act_d = 1'b0;
                    end

                    if (|btn_q) begin
                        tcnt_d = '0;
                    end else if (tcnt_q == TO_LAST) begin
                        state_d = S_IDLE;
                        to_d    = 1'b1;
                        act_d   = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        editing_d       = (state_q == S_EDIT);
        field_sel_d     = sel_q;
        field_en_d      = en_dec;
        sb_d            = step_q;
        timeout_pulse_d = to_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            btn_q           <= '0;
            btn2_q          <= '0;
            vld_q           <= 1'b0;
            armed_q         <= 1'b0;
            sel_q           <= '0;
            step_q          <= 2'b00;
            to_q            <= 1'b0;
            act_q           <= 1'b0;
            dir_up_q        <= 1'b0;
            phase_q         <= 1'b0;
            hcnt_q          <= '0;
            tcnt_q          <= '0;
            editing_q       <= 1'b0;
            field_sel_q     <= '0;
            field_en_q      <= '0;
            sb_q            <= 2'b00;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            btn_q           <= btn_d;
            btn2_q          <= btn2_d;
            vld_q           <= vld_d;
            armed_q         <= armed_d;
            sel_q           <= sel_d;
            step_q          <= step_d;
            to_q            <= to_d;
            act_q           <= act_d;
            dir_up_q        <= dir_up_d;
            phase_q         <= phase_d;
            hcnt_q          <= hcnt_d;
            tcnt_q          <= tcnt_d;
            editing_q       <= editing_d;
            field_sel_q     <= field_sel_d;
            field_en_q      <= field_en_d;
            sb_q            <= sb_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign bus.editing       = editing_q;
    assign bus.field_sel     = field_sel_q;
    assign bus.field_en      = field_en_q;
    assign bus.sb            = sb_q;
    assign bus.timeout_pulse = timeout_pulse_q;
endmodule

// File: tb/tb_edit_field_ctrl.sv
// Scoreboard bench for edit_field_ctrl: a behavioural model predicts the output
// vector for each sampled button set; a monitor compares it two edges later.
module tb_edit_field_ctrl;
    localparam int NF = 3;
    localparam int HOLD = 8;
    localparam int REP = 4;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    edit_field_ctrl_if #(.NUM_FIELDS(NF)) bus ();

    edit_field_ctrl #(
        .NUM_FIELDS(NF), .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int         tgt;
        logic [8:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   edge_n = 0;
    int   checks = 0;
    int   failures = 0;

    // Behavioural model state: mode, selection, which button is being held
    // (0 none, 1 up, 2 down), cycles held since its first step, idle cycles.
    bit         m_edit;
    int         m_sel;
    int         m_dir;
    int         m_held;
    int         m_idle;
    bit         m_primed;
    logic [3:0] m_prev;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [8:0] pack(bit ed, int sel, logic [1:0] stp, bit to);
        logic [2:0] en;
        en = ed ? 3'(1 << sel) : 3'b000;
        return {ed, 2'(sel), en, stp, to};
    endfunction

    task automatic model_reset();
        m_edit = 0; m_sel = 0; m_dir = 0; m_held = 0; m_idle = 0;
        m_primed = 0; m_prev = 4'b0;
    endtask

    // b = {edit, next, up, down} as sampled at one clock edge.
    task automatic model_step(input logic [3:0] b, input int tgt);
        logic [3:0] r;
        logic [1:0] stp;
        bit         to;
        exp_t       e;
        r = m_primed ? (b & ~m_prev) : 4'b0;
        m_primed = 1; m_prev = b; stp = 2'b00; to = 0;
        if (!m_edit) begin
            if (r[3]) begin m_edit = 1; m_sel = 0; m_idle = 0; m_dir = 0; end
        end else if (r[3]) begin
            m_edit = 0; m_dir = 0;
        end else begin
            if (r[2]) begin
                m_sel = (m_sel + 1) % NF; m_dir = 0;
            end else if (b[1] && b[0]) begin
                m_dir = 0;
            end else if (r[1]) begin
                stp = 2'b10; m_dir = 1; m_held = 0;
            end else if (r[0]) begin
                stp = 2'b01; m_dir = 2; m_held = 0;
            end else if ((m_dir == 1 && b[1]) || (m_dir == 2 && b[0])) begin
                m_held++;
                if (m_held == HOLD || (m_held > HOLD && (m_held - HOLD) % REP == 0))
                    stp = (m_dir == 1) ? 2'b10 : 2'b01;
            end else begin
                m_dir = 0;
            end
            if (b != 4'b0) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == TO) begin m_edit = 0; to = 1; m_dir = 0; end
            end
        end
        e.tgt = tgt;
        e.v = pack(m_edit, m_sel, stp, to);
        exp_q.push_back(e);
    endtask

    task automatic set_btn(input logic [3:0] b);
        bus.btn_edit = b[3]; bus.btn_next = b[2]; bus.btn_up = b[1]; bus.btn_down = b[0];
    endtask

    task automatic cyc(input logic [3:0] b);
        @(negedge clk);
        set_btn(b);
        model_step(b, edge_n + 3);
    endtask

    task automatic run(input logic [3:0] b, input int n);
        repeat (n) cyc(b);
    endtask

    task automatic release_rst(input logic [3:0] b);
        exp_t e;
        @(negedge clk);
        set_btn(b);
        rst = 1'b0;
        model_reset();
        e.v = 9'b0;
        e.tgt = edge_n + 1; exp_q.push_back(e);
        e.tgt = edge_n + 2; exp_q.push_back(e);
        model_step(b, edge_n + 3);
    endtask

    // Monitor: pops every expectation due at the current edge.
    exp_t       mon_e;
    logic [8:0] mon_act;
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].tgt <= edge_n) begin
                mon_e = exp_q.pop_front();
                mon_act = {bus.editing, bus.field_sel, bus.field_en, bus.sb, bus.timeout_pulse};
                checks++;
                if (mon_e.tgt != edge_n) begin
                    failures++;
                    $display("FAIL stale_expect edge=%0d due=%0d", edge_n, mon_e.tgt);
                end else if (mon_act !== mon_e.v) begin
                    failures++;
                    $display("FAIL outputs edge=%0d got ed/sel/en/sb/to=%b/%b/%b/%b/%b required %b/%b/%b/%b/%b",
                             edge_n, mon_act[8], mon_act[7:6], mon_act[5:3], mon_act[2:1], mon_act[0],
                             mon_e.v[8], mon_e.v[7:6], mon_e.v[5:3], mon_e.v[2:1], mon_e.v[0]);
                end else if (mon_e.v[2:0] != 3'b000) begin
                    $display("txn edge=%0d sel=%0d sb=%b timeout=%b ok",
                             edge_n, mon_act[7:6], mon_act[2:1], mon_act[0]);
                end
            end
        end
    end

    initial begin
        logic [3:0] b;
        set_btn(4'b0000);
        model_reset();
        repeat (3) @(negedge clk);
        release_rst(4'b0000);
        run(4'b0000, 3);

        // Entry, field cycling with wrap, exit.
        run(4'b1000, 2); run(4'b0000, 3);
        repeat (3) begin run(4'b0100, 1); run(4'b0000, 2); end
        run(4'b1000, 1); run(4'b0000, 3);

        // Single steps in EDIT, then ignored step in IDLE.
        run(4'b1000, 1); run(4'b0000, 2);
        run(4'b0010, 3); run(4'b0000, 2);
        run(4'b0001, 3); run(4'b0000, 2);
        run(4'b1000, 1); run(4'b0000, 2);
        run(4'b0010, 3); run(4'b0000, 2);

        // Auto-repeat on a 30-cycle down hold.
        run(4'b1000, 1); run(4'b0000, 2);
        run(4'b0001, 30); run(4'b0000, 6);

        // Conflicts: up+down, next+up same cycle, edit+next same cycle.
        run(4'b0011, 5); run(4'b0000, 2);
        run(4'b0110, 1); run(4'b0010, 3); run(4'b0000, 2);
        run(4'b1100, 1); run(4'b0000, 3);

        // Timeout when idle; none while a button is held.
        run(4'b1000, 1); run(4'b0000, 25);
        run(4'b1000, 1); run(4'b0000, 1); run(4'b0010, 30); run(4'b0000, 25);

        // Randomised segments, each followed by an idle stretch.
        b = 4'b0000;
        repeat (6) begin
            repeat (300) begin
                if ($urandom_range(0, 39) == 0) b[3] = ~b[3];
                if ($urandom_range(0, 14) == 0) b[2] = ~b[2];
                if ($urandom_range(0, 11) == 0) b[1] = ~b[1];
                if ($urandom_range(0, 11) == 0) b[0] = ~b[0];
                cyc(b);
            end
            b = 4'b0000;
            run(b, 25);
        end

        // Asynchronous reset mid-hold in EDIT.
        run(4'b1000, 1); run(4'b0000, 2); run(4'b0010, 12);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if ({bus.editing, bus.field_sel, bus.field_en, bus.sb, bus.timeout_pulse} !== 9'b0) begin
            failures++;
            $display("FAIL async_reset got %b required all zero",
                     {bus.editing, bus.field_sel, bus.field_en, bus.sb, bus.timeout_pulse});
        end
        repeat (2) @(negedge clk);
        release_rst(4'b0010);
        run(4'b0010, 10); run(4'b0000, 3);

        // Drain: every expectation must have been consumed.
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
